// File: rtl/pkg_framer.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_framer
//  Description : Packet framer between the acquisition data path and the UART
//                transmit PHY. Payload words are queued in an internal FIFO;
//                once PKT_LEN words are queued a frame is sent to the PHY one
//                word at a time: HEAD, PKT_LEN, payload[0..PKT_LEN-1] and,
//                when enabled, a 16-bit modulo-2^16 payload checksum.
//  Build macro : PKG_CHKSUM_EN - when defined, a checksum word closes each
//                frame; when undefined the checksum adder and the SUM state
//                are not built.
//  Ports       :
//    clk_sys   in   system clock (the only clock)
//    rst_n     in   asynchronous active-low reset
//    pkg_d     in   16-bit payload word
//    pkg_vld   in   one-cycle write strobe for pkg_d
//    pkg_done  out  one-cycle pulse when a frame has left the PHY
//    tx_data   out  registered word to the PHY, stable until tx_done
//    tx_vld    out  one-cycle pulse starting transmission of tx_data
//    tx_done   in   one-cycle pulse from the PHY, current word sent
//    ovf       out  sticky: a word was dropped because the FIFO was full
//    fifo_cnt  out  current FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module pkg_framer #(
    parameter int          PKT_LEN = 16,
    parameter int          DEPTH   = 64,
    parameter logic [15:0] HEAD    = 16'hEB90
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic [15:0]              pkg_d,
    input  logic                     pkg_vld,
    output logic                     pkg_done,
    output logic [15:0]              tx_data,
    output logic                     tx_vld,
    input  logic                     tx_done,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    localparam logic [c_cw-1:0] c_depth    = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_pkt_len  = c_cw'(PKT_LEN);
    localparam logic [c_cw-1:0] c_last_idx = c_cw'(PKT_LEN - 1);
    localparam logic [15:0]     c_len_word = 16'(PKT_LEN);

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [15:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_cnt;
    logic            r_ovf;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [15:0]     w_fifo_head;

    assign w_full      = (r_cnt == c_depth);
    // A pop in the same cycle frees the slot the write lands in, so a
    // write while full is only refused when nothing leaves.
    assign w_push      = pkg_vld && (!w_full || w_pop);
    assign w_drop      = pkg_vld && w_full && !w_pop;
    assign w_fifo_head = r_mem[r_rd_ptr];

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pkg_d;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_tx_data;
    logic [15:0]     w_tx_data_nxt;
    logic            r_tx_vld;
    logic            w_tx_vld_nxt;
    logic            r_pkg_done;
    logic            w_pkg_done_nxt;
    logic [c_cw-1:0] r_word_cnt;
    logic [c_cw-1:0] w_word_cnt_nxt;
`ifdef PKG_CHKSUM_EN
    logic [15:0]     r_sum;
    logic [15:0]     w_sum_nxt;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_vld   <= 1'b0;
            r_pkg_done <= 1'b0;
            r_word_cnt <= '0;
`ifdef PKG_CHKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_vld   <= w_tx_vld_nxt;
            r_pkg_done <= w_pkg_done_nxt;
            r_word_cnt <= w_word_cnt_nxt;
`ifdef PKG_CHKSUM_EN
            r_sum      <= w_sum_nxt;
`endif
        end
    end

    // Every word is launched from a state that only advances on tx_done,
    // so tx_vld can never overlap a word that is still in flight.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_vld_nxt   = 1'b0;
        w_pkg_done_nxt = 1'b0;
        w_word_cnt_nxt = r_word_cnt;
        w_pop          = 1'b0;
`ifdef PKG_CHKSUM_EN
        w_sum_nxt      = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_cnt >= c_pkt_len) begin
                    w_tx_data_nxt = HEAD;
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = S_HEAD;
                end
            end
            S_HEAD: begin
                if (tx_done) begin
                    w_tx_data_nxt = c_len_word;
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = S_LEN;
                end
            end
            S_LEN: begin
                if (tx_done) begin
                    w_tx_data_nxt  = w_fifo_head;
                    w_tx_vld_nxt   = 1'b1;
                    w_pop          = 1'b1;
                    w_word_cnt_nxt = '0;
`ifdef PKG_CHKSUM_EN
                    w_sum_nxt      = r_sum + w_fifo_head;
`endif
                    w_state_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_done) begin
                    // r_word_cnt indexes the payload word just sent
                    if (r_word_cnt < c_last_idx) begin
                        w_tx_data_nxt  = w_fifo_head;
                        w_tx_vld_nxt   = 1'b1;
                        w_pop          = 1'b1;
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
`ifdef PKG_CHKSUM_EN
                        w_sum_nxt      = r_sum + w_fifo_head;
`endif
                    end else begin
`ifdef PKG_CHKSUM_EN
                        w_tx_data_nxt = r_sum;
                        w_tx_vld_nxt  = 1'b1;
                        w_state_nxt   = S_SUM;
`else
                        w_state_nxt   = S_FIN;
`endif
                    end
                end
            end
            S_SUM: begin
                if (tx_done) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_pkg_done_nxt = 1'b1;
`ifdef PKG_CHKSUM_EN
                w_sum_nxt      = '0;
`endif
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_data  = r_tx_data;
    assign tx_vld   = r_tx_vld;
    assign pkg_done = r_pkg_done;
    assign ovf      = r_ovf;
    assign fifo_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkg_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkg_framer
//  Description : Self-checking bench for pkg_framer (PKT_LEN=4, DEPTH=8).
//                A PHY responder answers each tx_vld with tx_done after a
//                fixed or random delay; a queue model of accepted words
//                predicts every transmitted frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkg_framer;

    localparam int          PKT_LEN = 4;
    localparam int          DEPTH   = 8;
    localparam logic [15:0] HEAD    = 16'hEB90;
`ifdef PKG_CHKSUM_EN
    localparam int          NW      = PKT_LEN + 3;
`else
    localparam int          NW      = PKT_LEN + 2;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] pkg_d   = '0;
    logic        pkg_vld = 1'b0;
    logic        tx_done = 1'b0;
    logic        pkg_done;
    logic [15:0] tx_data;
    logic        tx_vld;
    logic        ovf;
    logic [3:0]  fifo_cnt;

    pkg_framer #(.PKT_LEN(PKT_LEN), .DEPTH(DEPTH), .HEAD(HEAD)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pkg_d   (pkg_d),
        .pkg_vld (pkg_vld),
        .pkg_done(pkg_done),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_done (tx_done),
        .ovf     (ovf),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    int cyc           = 0;
    int last_done_cyc = -100;
    int hdr_cyc       = 0;
    int last_pkg_cyc  = 0;
    int pkg_cnt       = 0;
    int vld_cnt       = 0;
    bit phy_hold      = 1'b0;
    bit phy_rand      = 1'b0;
    bit force_done    = 1'b0;

    logic [15:0] obs_q [$];   // words seen on tx_data at each tx_vld
    logic [15:0] m_q   [$];   // model: accepted, not yet framed payload

    // PHY responder and protocol monitor, sampling on the falling edge
    initial begin : phy_model
        bit          busy;
        bit          busy_before;
        int          remain;
        int          frame_pos;
        logic [15:0] held;
        busy = 0; remain = 0; frame_pos = 0; held = '0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            tx_done = 1'b0;
            if (!rst_n) begin
                busy = 0;
                frame_pos = 0;
                continue;
            end
            busy_before = busy;
            if (busy) begin
                if (phy_hold) begin
                    if (force_done) begin
                        tx_done = 1'b1; busy = 0; force_done = 1'b0;
                    end
                end else begin
                    remain--;
                    if (remain <= 0) begin
                        tx_done = 1'b1; busy = 0;
                    end
                end
                if (tx_done) begin
                    last_done_cyc = cyc;
                    total++;
                    if (tx_data !== held) begin
                        bad++;
                        $display("FAIL tx_data_hold: got %h want %h", tx_data, held);
                    end
                end
            end
            if (tx_vld === 1'b1) begin
                vld_cnt++;
                total++;
                if (busy_before) begin
                    bad++;
                    $display("FAIL tx_vld_overlap: got tx_vld=1 want 0 while word in flight (cycle %0d)", cyc);
                end
                if (frame_pos == 0) hdr_cyc = cyc;
                frame_pos++;
                obs_q.push_back(tx_data);
                held   = tx_data;
                busy   = 1;
                remain = phy_rand ? int'($urandom_range(1, 12)) : 10;
            end
            if (pkg_done === 1'b1) begin
                pkg_cnt++;
                last_pkg_cyc = cyc;
                frame_pos = 0;
                total++;
                if (cyc - last_done_cyc != 2) begin
                    bad++;
                    $display("FAIL pkg_done_latency: got %0d want 2 cycles after last tx_done",
                             cyc - last_done_cyc);
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk_sys); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_word(input logic [15:0] d, input bit accept);
        @(posedge clk_sys); #1;
        pkg_d   = d;
        pkg_vld = 1'b1;
        @(posedge clk_sys); #1;
        pkg_vld = 1'b0;
        if (accept) m_q.push_back(d);
    endtask

    task automatic wait_pkg(input int target);
        int budget;
        budget = 0;
        while (pkg_cnt < target && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
        end
        @(negedge clk_sys);
        total++;
        if (pkg_cnt < target) begin
            bad++;
            $display("FAIL wait_pkg_timeout: got pkg_cnt=%0d want %0d", pkg_cnt, target);
        end
    endtask

    // Build each expected frame from the model queue and compare word by word
    task automatic check_frames(input int n);
        logic [15:0] exp_w [$];
        logic [15:0] sum;
        logic [15:0] got;
        for (int f = 0; f < n; f++) begin
            exp_w.delete();
            sum = 16'h0000;
            exp_w.push_back(HEAD);
            exp_w.push_back(16'(PKT_LEN));
            for (int i = 0; i < PKT_LEN; i++) begin
                exp_w.push_back(m_q[0]);
                sum = sum + m_q[0];
                void'(m_q.pop_front());
            end
`ifdef PKG_CHKSUM_EN
            exp_w.push_back(sum);
`endif
            for (int i = 0; i < exp_w.size(); i++) begin
                total++;
                if (obs_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_word[%0d.%0d]: got nothing want %h", f, i, exp_w[i]);
                end else begin
                    got = obs_q.pop_front();
                    if (got !== exp_w[i]) begin
                        bad++;
                        $display("FAIL frame_word[%0d.%0d]: got %h want %h", f, i, got, exp_w[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_sys);
        total++;
        if ({tx_data, tx_vld, pkg_done, ovf, fifo_cnt} !== 23'd0) begin
            bad++;
            $display("FAIL reset_values: got data=%h vld=%b done=%b ovf=%b cnt=%0d want all 0",
                     tx_data, tx_vld, pkg_done, ovf, fifo_cnt);
        end
    endtask

    task automatic test_basic_frame();
        int base;
        phy_rand = 1'b0;
        base = pkg_cnt;
        write_word(16'h0001, 1'b1);
        write_word(16'h0002, 1'b1);
        write_word(16'h0003, 1'b1);
        write_word(16'h0004, 1'b1);
        @(negedge clk_sys);
        total++;
        if (tx_vld !== 1'b0) begin
            bad++;
            $display("FAIL start_early: got tx_vld=%b want 0", tx_vld);
        end
        @(negedge clk_sys);
        total++;
        if (tx_vld !== 1'b1 || tx_data !== HEAD) begin
            bad++;
            $display("FAIL start_latency: got vld=%b data=%h want 1/%h", tx_vld, tx_data, HEAD);
        end
        wait_pkg(base + 1);
        check_frames(1);
        total++;
        if (last_pkg_cyc - hdr_cyc != NW * 11 + 1) begin
            bad++;
            $display("FAIL frame_duration: got %0d want %0d", last_pkg_cyc - hdr_cyc, NW * 11 + 1);
        end
        repeat (20) @(negedge clk_sys);
        total++;
        if (pkg_cnt != base + 1) begin
            bad++;
            $display("FAIL single_pkg_done: got %0d want %0d", pkg_cnt - base, 1);
        end
    endtask

    task automatic test_chksum_wrap();
        int base;
        base = pkg_cnt;
        write_word(16'hFFFF, 1'b1);
        write_word(16'h0002, 1'b1);
        write_word(16'h0000, 1'b1);
        write_word(16'h0000, 1'b1);
        wait_pkg(base + 1);
        check_frames(1);
    endtask

    task automatic test_below_threshold();
        int v0;
        int base;
        v0 = vld_cnt;
        base = pkg_cnt;
        for (int i = 0; i < 3; i++) write_word(16'($urandom), 1'b1);
        repeat (40) @(negedge clk_sys);
        total++;
        if (vld_cnt != v0 || fifo_cnt !== 4'd3) begin
            bad++;
            $display("FAIL below_threshold: got vld_count=%0d cnt=%0d want 0/3", vld_cnt - v0, fifo_cnt);
        end
        write_word(16'($urandom), 1'b1);
        wait_pkg(base + 1);
        check_frames(1);
        total++;
        if (fifo_cnt !== 4'd0) begin
            bad++;
            $display("FAIL drain_cnt: got %0d want 0", fifo_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int budget;
        base = pkg_cnt;
        for (int i = 0; i < 8; i++) write_word(16'($urandom), 1'b1);
        budget = 0;
        while (pkg_done !== 1'b1 && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
        end
        @(negedge clk_sys);
        total++;
        if (tx_vld !== 1'b1 || tx_data !== HEAD) begin
            bad++;
            $display("FAIL b2b_restart: got vld=%b data=%h want 1/%h", tx_vld, tx_data, HEAD);
        end
        wait_pkg(base + 2);
        check_frames(2);
    endtask

    task automatic test_random();
        int base;
        int words;
        int frames_done;
        int n;
        phy_rand = 1'b1;
        base = pkg_cnt;
        words = 0;
        frames_done = 0;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk_sys);
                write_word(16'($urandom), 1'b1);
            end
            words += n;
            wait_pkg(base + words / PKT_LEN);
            check_frames(words / PKT_LEN - frames_done);
            frames_done = words / PKT_LEN;
        end
        phy_rand = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int pc;
        int v0;
        int budget;
        for (int i = 0; i < 4; i++) write_word(16'($urandom), 1'b1);
        budget = 0;
        while (obs_q.size() < 3 && budget < 3000) begin
            @(negedge clk_sys);
            budget++;
        end
        repeat (2) @(posedge clk_sys);
        #1 rst_n = 1'b0;
        pc = pkg_cnt;
        @(negedge clk_sys);
        total++;
        if ({tx_data, tx_vld, pkg_done, ovf, fifo_cnt} !== 23'd0) begin
            bad++;
            $display("FAIL midframe_reset: got data=%h vld=%b done=%b ovf=%b cnt=%0d want all 0",
                     tx_data, tx_vld, pkg_done, ovf, fifo_cnt);
        end
        @(posedge clk_sys);
        #1 rst_n = 1'b1;
        m_q.delete();
        obs_q.delete();
        v0 = vld_cnt;
        repeat (40) @(negedge clk_sys);
        total++;
        if (pkg_cnt != pc || vld_cnt != v0 || fifo_cnt !== 4'd0) begin
            bad++;
            $display("FAIL after_reset_quiet: got done=%0d vld=%0d cnt=%0d want 0/0/0",
                     pkg_cnt - pc, vld_cnt - v0, fifo_cnt);
        end
    endtask

    task automatic test_overflow();
        int base;
        int budget;
        base = pkg_cnt;
        phy_hold = 1'b1;
        for (int i = 0; i < 10; i++) write_word(16'h1000 + 16'(i), (i < DEPTH));
        @(negedge clk_sys);
        total++;
        if (fifo_cnt !== 4'd8 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow: got cnt=%0d ovf=%b want 8/1", fifo_cnt, ovf);
        end
        force_done = 1'b1;
        budget = 0;
        while (obs_q.size() < 2 && budget < 200) begin
            @(negedge clk_sys);
            budget++;
        end
        // LEN word is in flight: finish it while writing, so pop and push coincide
        @(posedge clk_sys); #1;
        pkg_d      = 16'hABCD;
        pkg_vld    = 1'b1;
        force_done = 1'b1;
        @(posedge clk_sys); #1;
        pkg_vld = 1'b0;
        m_q.push_back(16'hABCD);
        @(negedge clk_sys);
        total++;
        if (fifo_cnt !== 4'd8) begin
            bad++;
            $display("FAIL full_pop_push: got cnt=%0d want 8", fifo_cnt);
        end
        phy_hold = 1'b0;
        wait_pkg(base + 2);
        check_frames(2);
        total++;
        if (fifo_cnt !== 4'd1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_tail: got cnt=%0d ovf=%b want 1/1", fifo_cnt, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_chksum_wrap();
        test_below_threshold();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
